alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
- Execute-stage ALU for the MIPS datapath, the consumer of the 3-bit alu_operation code produced by ALU control.
- Accepts an operation and two operands through a start/busy/done handshake.
- Logic and arithmetic ops complete in one cycle; MUL runs as a multi-cycle shift-add sequence.
- The controller stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand and result width in bits (≥ 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when state is IDLE or DONE
- alu_operation  input  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 MUL; others reserved
- a  input  WIDTH  operand A; sampled on accept only
- b  input  WIDTH  operand B; sampled on accept only
- result  output  WIDTH  registered result; holds until the next completion
- zero  output  1  registered (result == 0); updated together with result
- busy  output  1  high while a MUL is in progress
- done  output  1  one-cycle pulse with a new valid result

Behaviour:
- Reset (asynchronous, any state, including mid-MUL): state=IDLE, result=0, zero=0, busy=0, done=0, counter=0, MUL internals cleared. The in-flight op is discarded and no done is issued.
- States: IDLE, MUL, DONE. busy=1 only in MUL; done=1 only in DONE.
- Accept: start=1 in IDLE or DONE. Back-to-back issue in the DONE cycle is legal. start in MUL is ignored and not queued.
- Single-cycle ops, accepted at cycle N:
  - result/zero are written at the edge ending N.
  - state=DONE during N+1, so done is high in cycle N+1.
  - ADD/SUB: modulo 2^WIDTH; no overflow flag.
  - SLT: signed compare; result = {WIDTH-1 zeros, a<b}.
  - Reserved codes: result=0, zero=1, same 1-cycle latency.
- MUL, accepted at cycle N:
  - Latch multiplicand=a, multiplier=b, acc=0, count=0; go to MUL.
  - Each MUL cycle: if multiplier[0], acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count++.
  - After WIDTH iterations (count==WIDTH-1 on the last one), write result = low WIDTH bits of acc including the final add; update zero; go to DONE.
  - busy is high N+1..N+WIDTH; done is high in N+WIDTH+1.
  - Product is the unsigned low half, which also equals the signed low half. No high word.
- DONE → IDLE when start=0. On start=1, behave as the accept from IDLE.
- result and zero never change except at completion or reset.

Optional Feature:
- Macro: ALU_EXEC_EARLY_TERM_EN.
- Defined: MUL completes on the iteration where the post-shift multiplier is 0.
  - Latency = max(1, index of highest set bit of b + 1) MUL cycles.
  - b=0: 1 MUL cycle, result 0, done at N+2.
- Undefined: fixed WIDTH MUL cycles.
- Results are identical either way.

Decomposition:
- Package alu_exec_pkg:
  - opcode constants OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_MUL;
  - state encoding constants ST_IDLE, ST_MUL, ST_DONE;
  - counter width $clog2(WIDTH).
- One sub-module: seq_multiplier, holding the shift-add datapath and counter.
  - Interface: load, a, b, step → product, last.
  - Top level keeps the FSM, the combinational single-cycle ops and the result/zero registers.

Test Plan:
- ADD a=5, b=7 → done at N+1, result=12, zero=0, busy never high. SUB a=3, b=3 → result=0, zero=1.
- SLT a=0xFFFFFFFF, b=1 → result=1. SLT a=1, b=0xFFFFFFFF → result=0. Reserved op 100 → result=0, zero=1.
- MUL a=6, b=7 → busy high 32 cycles, done at N+33, result=42. MUL 0xFFFFFFFF×2 → 0xFFFFFFFE. start pulsed mid-MUL → ignored, a single done.
- Back-to-back: ADD 1+1, then MUL 3×4 issued in the DONE cycle → results 2 then 12, no idle gap.
- Reset asserted asynchronously at MUL cycle 10 → outputs 0 immediately, no done. A new ADD 2+2 afterwards → 4 at N+1.
- ALU_EXEC_EARLY_TERM_EN: MUL a=9, b=5 → done at N+4 (3 MUL cycles), result=45. b=0 → done at N+2, result 0. Undefined: same results at N+33.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared opcode, state and sizing definitions for the execute-stage ALU.
package alu_exec_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  localparam logic [2:0] OP_MUL = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Start/busy/done request bus between the pipeline controller and the execute ALU.
interface alu_exec_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       alu_operation;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (output start, alu_operation, a, b,
                  input  result, zero, busy, done);
  modport slave  (input  start, alu_operation, a, b,
                  output result, zero, busy, done);
endinterface

// File: rtl/alu_exec_unit_seq_multiplier.sv
// Shift-add multiplier datapath: one partial-product add per step, low WIDTH bits only.
// ALU_EXEC_EARLY_TERM_EN ends the sequence once the remaining multiplier bits are all zero.
module seq_multiplier
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic [WIDTH-1:0] product,
  output logic             last
);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, addend;
  logic [CW-1:0]    count_q;

  assign addend  = mplier_q[0] ? mcand_q : '0;
  // product already includes this step's add so completion needs no extra cycle
  assign product = acc_q + addend;

`ifdef ALU_EXEC_EARLY_TERM_EN
  assign last = (mplier_q[WIDTH-1:1] == '0) || (count_q == LAST_CNT);
`else
  assign last = (count_q == LAST_CNT);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else if (load) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      count_q  <= '0;
    end else if (step) begin
      acc_q    <= product;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q + CW'(1);
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops plus a multi-cycle MUL behind start/busy/done.
// Optional macro ALU_EXEC_EARLY_TERM_EN (in seq_multiplier) shortens MUL latency.
//   state   | meaning
//   ST_IDLE | waiting for start
//   ST_MUL  | shift-add multiply in progress, busy=1
//   ST_DONE | new result valid, done=1; start here is accepted back-to-back
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  alu_exec_unit_if.slave bus
);
  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] result_q, res_d, alu_value, mul_product;
  logic             zero_q, res_we, mul_load, mul_step, mul_last;

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .load    (mul_load),
    .a       (bus.a),
    .b       (bus.b),
    .step    (mul_step),
    .product (mul_product),
    .last    (mul_last)
  );

  always_comb begin
    alu_value = '0;
    case (bus.alu_operation)
      OP_AND:  alu_value = bus.a & bus.b;
      OP_OR:   alu_value = bus.a | bus.b;
      OP_ADD:  alu_value = bus.a + bus.b;
      OP_SUB:  alu_value = bus.a - bus.b;
      OP_SLT:  alu_value = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: alu_value = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    res_we   = 1'b0;
    res_d    = alu_value;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          if (bus.alu_operation == OP_MUL) begin
            mul_load = 1'b1;
            state_d  = ST_MUL;
          end else begin
            res_we  = 1'b1;
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          res_we  = 1'b1;
          res_d   = mul_product;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (res_we) begin
        result_q <= res_d;
        zero_q   <= (res_d == '0);
      end
    end
  end

  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.busy   = (state_q == ST_MUL);
  assign bus.done   = (state_q == ST_DONE);
endmodule
